// File: rtl/aes_io_pkg.sv
// Shared definitions for the AES host I/O block: FSM states, register
// addresses, CTRL/STATUS bit positions and a word-extraction helper.
package aes_io_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2,
    DONE      = 2'd3
  } state_t;

  // Word addresses; each 128-bit bank occupies four consecutive words.
  localparam logic [3:0] ADDR_KEY0   = 4'd0;
  localparam logic [3:0] ADDR_MSG0   = 4'd4;
  localparam logic [3:0] ADDR_RES0   = 4'd8;
  localparam logic [3:0] ADDR_CTRL   = 4'd12;
  localparam logic [3:0] ADDR_STATUS = 4'd13;

  localparam int CTRL_START_BIT     = 0;
  localparam int STATUS_BUSY_BIT    = 0;
  localparam int STATUS_DONE_BIT    = 1;
  localparam int STATUS_TIMEOUT_BIT = 2;

  // Word 0 is the most significant 32 bits of the flat vector.
  function automatic logic [31:0] word_of(input logic [127:0] flat,
                                          input logic [1:0]   idx);
    return flat[(3 - int'(idx)) * 32 +: 32];
  endfunction

endpackage

// File: rtl/aes_word_bank.sv
// Four 32-bit words written one at a time by word select, presented as a
// single 128-bit vector with word 0 in bits 127:96.
module aes_word_bank (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         we,
  input  logic [1:0]   sel,
  input  logic [31:0]  wdata,
  output logic [127:0] data
);

  logic [31:0] words [4];

  // Word storage; one word updated per write strobe.
  // NOTE: this small array is reset like ordinary flops because its zero
  // value is visible to the host and the controller straight after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) words[i] <= '0;
    end else if (we) begin
      words[sel] <= wdata;
    end
  end

  assign data = {words[0], words[1], words[2], words[3]};

endmodule

// File: rtl/aes_host_io.sv
// Host-side end of the AES decrypt handshake: register map for key,
// ciphertext, result and status, plus the request/response FSM towards
// the AES controller. Optional WAIT_DONE watchdog: AES_IO_TIMEOUT_EN.
module aes_host_io
  import aes_io_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         wr_en,
  input  logic         rd_en,
  input  logic [3:0]   addr,
  input  logic [31:0]  wr_data,
  output logic [31:0]  rd_data,
  output logic         done_irq,
  output logic [127:0] key,
  output logic [127:0] msg_en,
  output logic         io_ready,
  input  logic [127:0] msg_de,
  input  logic         aes_ready
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must lie in 1..65535");
  end

  state_t         state, next_state;
  logic           busy;
  logic           io_ready_d;
  logic           start_req;
  logic           timeout_hit;
  logic           done_flag;
  logic           timeout_flag;
  logic [127:0]   result;
  logic [31:0]    status_word;
  logic [31:0]    rd_next;

  // Host writes only land while idle; anything else is silently dropped.
  assign start_req = wr_en && (state == IDLE) && (addr == ADDR_CTRL)
                     && wr_data[CTRL_START_BIT];

  aes_word_bank u_key_bank (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (wr_en && (state == IDLE) && (addr[3:2] == ADDR_KEY0[3:2])),
    .sel     (addr[1:0]),
    .wdata   (wr_data),
    .data    (key)
  );

  aes_word_bank u_msg_bank (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (wr_en && (state == IDLE) && (addr[3:2] == ADDR_MSG0[3:2])),
    .sel     (addr[1:0]),
    .wdata   (wr_data),
    .data    (msg_en)
  );

`ifdef AES_IO_TIMEOUT_EN
  logic [15:0] wait_cnt;

  // Watchdog counter: cleared on the way into WAIT_DONE, counts while there.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 wait_cnt <= '0;
    else if (state == START)      wait_cnt <= '0;
    else if (state == WAIT_DONE)  wait_cnt <= wait_cnt + 16'd1;
  end

  // A real result in the same cycle as expiry wins over the abort.
  assign timeout_hit = (state == WAIT_DONE) && !aes_ready
                       && (wait_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // State register.
  // NOTE: sequential state uses non-blocking assignment so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state logic.
  // NOTE: the default assignment at the top keeps this block free of latches.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (start_req) next_state = START;
      START:     next_state = WAIT_DONE;
      WAIT_DONE: if (aes_ready || timeout_hit) next_state = DONE;
      DONE:      next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // State-decoded outputs; io_ready is requested for every cycle spent in
  // WAIT_DONE so it falls on the same edge that captures the result.
  always_comb begin
    busy       = (state != IDLE);
    done_irq   = (state == DONE);
    io_ready_d = (next_state == WAIT_DONE);
  end

  // Registered request level; the async reset drops it immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) io_ready <= 1'b0;
    else          io_ready <= io_ready_d;
  end

  // Result capture only on a genuine response while waiting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                              result <= '0;
    else if (state == WAIT_DONE && aes_ready)  result <= msg_de;
  end

  // Sticky completion flags, cleared by the next accepted START.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_flag    <= 1'b0;
      timeout_flag <= 1'b0;
    end else if (start_req) begin
      done_flag    <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      if (state == DONE) done_flag    <= 1'b1;
      if (timeout_hit)   timeout_flag <= 1'b1;
    end
  end

  // STATUS word assembly.
  always_comb begin
    status_word                     = '0;
    status_word[STATUS_BUSY_BIT]    = busy;
    status_word[STATUS_DONE_BIT]    = done_flag;
    status_word[STATUS_TIMEOUT_BIT] = timeout_flag;
  end

  // Read decode; CTRL is write-only and unmapped addresses read as zero.
  always_comb begin
    rd_next = '0;
    case (addr[3:2])
      ADDR_KEY0[3:2]: rd_next = word_of(key, addr[1:0]);
      ADDR_MSG0[3:2]: rd_next = word_of(msg_en, addr[1:0]);
      ADDR_RES0[3:2]: rd_next = word_of(result, addr[1:0]);
      default:        if (addr == ADDR_STATUS) rd_next = status_word;
    endcase
  end

  // Read data register; a same-cycle write is seen only by later reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   rd_data <= '0;
    else if (rd_en) rd_data <= rd_next;
  end

endmodule

// File: tb/tb_aes_host_io.sv
// Directed bench for aes_host_io with a small AES-controller model and a
// read-data scoreboard. Covers the AES_IO_TIMEOUT_EN build when defined.
module tb_aes_host_io;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         wr_en = 1'b0;
  logic         rd_en = 1'b0;
  logic [3:0]   addr = '0;
  logic [31:0]  wr_data = '0;
  logic [31:0]  rd_data;
  logic         done_irq;
  logic [127:0] key;
  logic [127:0] msg_en;
  logic         io_ready;
  logic [127:0] msg_de = '0;
  logic         aes_ready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t exp_q[$];

  localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] MSG1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] MSG2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] RES1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] RES2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] RES3 = 128'h6bc1bee22e409f96e93d7e117393172a;

  aes_host_io #(.TIMEOUT_CYCLES(100)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .addr      (addr),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .done_irq  (done_irq),
    .key       (key),
    .msg_en    (msg_en),
    .io_ready  (io_ready),
    .msg_de    (msg_de),
    .aes_ready (aes_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic push_result(input logic [127:0] r);
    for (int i = 0; i < 4; i++)
      push_exp($sformatf("result_w%0d", i), r[127 - 32*i -: 32]);
  endtask

  task automatic write(input logic [3:0] a, input logic [31:0] d);
    wr_en = 1'b1; addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic write_bank(input logic [3:0] base, input logic [127:0] v);
    for (int i = 0; i < 4; i++) write(base + 4'(i), v[127 - 32*i -: 32]);
  endtask

  // Issue a read and compare against the oldest scoreboard entry.
  task automatic read_pop(input logic [3:0] a);
    exp_t e;
    rd_en = 1'b1; addr = a;
    tick();
    rd_en = 1'b0;
    n_checks++;
    assert (exp_q.size() > 0) else begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed read 0x%0h at addr %0d, expected a queued value",
             rd_data, a);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(e.tag, rd_data, e.val);
    end
  endtask

  task automatic read_results();
    for (int i = 0; i < 4; i++) read_pop(4'(8 + i));
  endtask

  // START then act as the controller: respond `delay` cycles after
  // io_ready is first seen high.
  task automatic run_op(input int delay, input logic [127:0] res);
    int hi;
    int irq;
    hi = 0;
    irq = 0;
    write(4'd12, 32'h1);
    for (int i = 0; i < 8 && !io_ready; i++) tick();
    if (io_ready) hi = 1;
    for (int i = 0; i < delay; i++) begin
      tick();
      if (io_ready) hi++;
      if (done_irq) irq++;
    end
    aes_ready = 1'b1; msg_de = res;
    push_result(res);
    tick();
    aes_ready = 1'b0; msg_de = ~res;
    for (int i = 0; i < 5; i++) begin
      if (io_ready) hi++;
      if (done_irq) irq++;
      tick();
    end
    check("io_ready_cycles", 128'(hi), 128'(delay + 1));
    check("done_irq_pulses", 128'(irq), 128'd1);
    read_results();
  endtask

  initial begin
    int hi;
    int irq;

    // 1: reset values
    tick();
    check("rst_io_ready", io_ready, 0);
    check("rst_done_irq", done_irq, 0);
    check("rst_rd_data", rd_data, 0);
    tick(); tick();
    reset_n = 1'b1;
    tick();
    push_exp("rst_status", 32'h0); read_pop(4'd13);
    push_exp("rst_result_w0", 32'h0); read_pop(4'd8);
    push_exp("rst_key_w0", 32'h0); read_pop(4'd0);

    // 2: load, same-address read/write, full handshake
    write_bank(4'd0, KEY1);
    for (int i = 0; i < 3; i++) write(4'(4 + i), MSG1[127 - 32*i -: 32]);
    write(4'd7, 32'hcafef00d);
    push_exp("rw_same_addr_old", 32'hcafef00d);
    wr_en = 1'b1; wr_data = MSG1[31:0];
    read_pop(4'd7);
    wr_en = 1'b0;
    push_exp("msg_w3_new", MSG1[31:0]); read_pop(4'd7);
    push_exp("key_w1", 32'h04050607); read_pop(4'd1);
    check("key_out", key, KEY1);
    check("msg_en_out", msg_en, MSG1);
    push_exp("ctrl_reads_zero", 32'h0); read_pop(4'd12);
    push_exp("unmapped_reads_zero", 32'h0); read_pop(4'd15);
    run_op(20, RES1);
    push_exp("status_done", 32'h2); read_pop(4'd13);

    // 3: writes while busy are dropped; repeated START ignored
    write(4'd12, 32'h1);
    for (int i = 0; i < 8 && !io_ready; i++) tick();
    check("t3_io_ready_up", io_ready, 1);
    tick(); tick(); tick();
    write(4'd0, 32'hdeadbeef);
    write(4'd4, 32'h12345678);
    write(4'd12, 32'h1);
    check("key_locked", key, KEY1);
    check("msg_locked", msg_en, MSG1);
    push_exp("status_busy", 32'h1); read_pop(4'd13);
    push_exp("key_w0_locked", 32'h00010203); read_pop(4'd0);
    aes_ready = 1'b1; msg_de = RES2;
    push_result(RES2);
    tick();
    aes_ready = 1'b0; msg_de = '0;
    check("t3_done_irq", done_irq, 1);
    check("t3_io_ready_drop", io_ready, 0);
    hi = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (io_ready) hi++;
    end
    check("second_start_ignored", 128'(hi), 128'd0);
    read_results();
    push_exp("t3_status_done", 32'h2); read_pop(4'd13);

    // 4: stray aes_ready while idle
    irq = 0;
    aes_ready = 1'b1; msg_de = {$urandom, $urandom, $urandom, $urandom};
    tick();
    aes_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (done_irq) irq++;
      tick();
    end
    check("stray_no_irq", 128'(irq), 128'd0);
    push_result(RES2);
    read_results();
    push_exp("stray_status", 32'h2); read_pop(4'd13);

    // 5: asynchronous reset during WAIT_DONE
    write(4'd12, 32'h1);
    for (int i = 0; i < 8 && !io_ready; i++) tick();
    tick(); tick(); tick();
    check("t5_io_ready_before", io_ready, 1);
    #2 reset_n = 1'b0;
    #1;
    check("async_io_ready", io_ready, 0);
    check("async_key", key, 0);
    check("async_msg_en", msg_en, 0);
    check("async_done_irq", done_irq, 0);
    tick(); tick(); tick();
    reset_n = 1'b1;
    tick();
    push_result(128'h0);
    read_results();
    push_exp("t5_status", 32'h0); read_pop(4'd13);
    write_bank(4'd0, KEY2);
    write_bank(4'd4, MSG2);
    check("t5_key_out", key, KEY2);
    check("t5_msg_out", msg_en, MSG2);
    run_op(5, RES3);
    push_exp("t5_status_done", 32'h2); read_pop(4'd13);

    // 6: no response from the controller
    write(4'd12, 32'h1);
    hi = 0;
    irq = 0;
`ifdef AES_IO_TIMEOUT_EN
    for (int i = 0; i < 150; i++) begin
      tick();
      if (io_ready) hi++;
      if (done_irq) irq++;
    end
    check("timeout_io_ready_cycles", 128'(hi), 128'd100);
    check("timeout_irq_pulses", 128'(irq), 128'd1);
    check("timeout_io_ready_low", io_ready, 0);
    push_result(RES3);
    read_results();
    push_exp("timeout_status", 32'h6); read_pop(4'd13);
`else
    for (int i = 0; i < 150; i++) begin
      tick();
      if (done_irq) irq++;
    end
    check("no_timeout_io_ready_held", io_ready, 1);
    check("no_timeout_no_irq", 128'(irq), 128'd0);
    push_exp("no_timeout_status", 32'h1); read_pop(4'd13);
    aes_ready = 1'b1; msg_de = RES1;
    push_result(RES1);
    tick();
    aes_ready = 1'b0; msg_de = '0;
    check("late_done_irq", done_irq, 1);
    tick();
    read_results();
    push_exp("late_status", 32'h2); read_pop(4'd13);
`endif
    run_op(3, RES2);
    push_exp("final_status", 32'h2); read_pop(4'd13);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
